// File: rtl/ipf_lcu_sched.sv
// LCU scheduler for the IPF filter core: walks a 128x128 frame in LCU raster order,
// fetches per-LCU parameters and streams pixels. Optional watchdog: IPF_SCHED_TIMEOUT_EN.
`timescale 1ns/1ps
module ipf_lcu_sched #(
  parameter int unsigned FRAME_W = 128,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  cfg_lcu_size,
  output logic [5:0]  prm_addr,
  input  logic [23:0] prm_data,
  output logic [13:0] pix_addr,
  input  logic [7:0]  pix_data,
  output logic        in_en,
  output logic [7:0]  din,
  output logic [1:0]  ipf_type,
  output logic [4:0]  ipf_band_pos,
  output logic        ipf_wo_class,
  output logic [15:0] ipf_offset,
  output logic [2:0]  lcu_x,
  output logic [2:0]  lcu_y,
  output logic [1:0]  lcu_size,
  input  logic        busy,
  input  logic        finish,
  output logic        done,
  output logic        err
);

  localparam int unsigned ROW_SH = $clog2(FRAME_W);

  typedef enum logic [2:0] {
    S_IDLE, S_PARAM1, S_PARAM2, S_STREAM, S_WAIT_FIN, S_DONE
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_size;
  logic [2:0]  r_x, r_y, r_lcu_x, r_lcu_y;
  logic [5:0]  r_prm_addr, r_row, r_col;
  logic [13:0] r_pix_addr;
  logic        r_iss_done, r_dvld, r_skid_v, r_in_en, r_done, r_err;
  logic [7:0]  r_skid, r_din;
  logic [12:0] r_out_cnt;
  logic [23:0] r_prm;

  logic [5:0]  w_n_m1, w_nxt_col, w_nxt_row, w_nxt_idx;
  logic [2:0]  w_l_m1, w_nx, w_ny;
  logic [12:0] w_nn;
  logic [13:0] w_base, w_nxt_addr;
  logic        w_col_last, w_row_last, w_issue, w_out, w_out_last;
  logic        w_last_lcu, w_fin, w_to;

  // LCU geometry derived from the latched size
  assign w_n_m1     = 6'((32'd16 << r_size) - 32'd1);
  assign w_l_m1     = 3'((32'd8 >> r_size) - 32'd1);
  assign w_nn       = 13'(32'd256 << {r_size, 1'b0});
  assign w_base     = 14'((32'(r_y) << (ROW_SH + 4 + 32'(r_size))) + (32'(r_x) << (4 + 32'(r_size))));
  assign w_col_last = (r_col == w_n_m1);
  assign w_row_last = (r_row == w_n_m1);
  assign w_nxt_col  = w_col_last ? 6'd0 : r_col + 6'd1;
  assign w_nxt_row  = w_col_last ? r_row + 6'd1 : r_row;
  assign w_nxt_addr = 14'(32'(w_base) + (32'(w_nxt_row) << ROW_SH) + 32'(w_nxt_col));

  // First read goes out during PARAM2 so data lands as STREAM begins
  assign w_issue    = ((r_state == S_PARAM2) || ((r_state == S_STREAM) && !r_iss_done)) && !busy;
  assign w_out      = (r_state == S_STREAM) && !busy && (r_skid_v || r_dvld);
  assign w_out_last = w_out && (r_out_cnt == (w_nn - 13'd1));

  assign w_last_lcu = (r_x == w_l_m1) && (r_y == w_l_m1);
  assign w_nx       = (r_x == w_l_m1) ? 3'd0 : r_x + 3'd1;
  assign w_ny       = (r_x == w_l_m1) ? r_y + 3'd1 : r_y;
  assign w_nxt_idx  = 6'((32'(w_ny) << (32'd3 - 32'(r_size))) | 32'(w_nx));
  assign w_fin      = (r_state == S_WAIT_FIN) && (finish || w_to);

`ifdef IPF_SCHED_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] r_to_cnt;

  assign w_to = (r_state == S_WAIT_FIN) && (r_to_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset || (r_state != S_WAIT_FIN)) r_to_cnt <= '0;
    else                                  r_to_cnt <= r_to_cnt + TO_W'(1);
  end
`else
  assign w_to = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:     if (start && (cfg_lcu_size != 2'd3)) w_state_nxt = S_PARAM1;
      S_PARAM1:   w_state_nxt = S_PARAM2;
      S_PARAM2:   w_state_nxt = S_STREAM;
      S_STREAM:   if (w_out_last) w_state_nxt = S_WAIT_FIN;
      S_WAIT_FIN: if (w_fin) w_state_nxt = w_last_lcu ? S_DONE : S_PARAM1;
      S_DONE:     w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_size <= '0; r_x <= '0; r_y <= '0; r_lcu_x <= '0; r_lcu_y <= '0;
      r_prm_addr <= '0; r_pix_addr <= '0; r_row <= '0; r_col <= '0;
      r_iss_done <= 1'b0; r_dvld <= 1'b0; r_skid_v <= 1'b0; r_skid <= '0;
      r_in_en <= 1'b0; r_din <= '0; r_out_cnt <= '0; r_prm <= '0;
      r_done <= 1'b0; r_err <= 1'b0;
    end else begin
      r_done  <= (w_state_nxt == S_DONE);
      r_in_en <= w_out;
      r_dvld  <= w_issue;
      if ((r_state == S_IDLE) && start) begin
        if (cfg_lcu_size == 2'd3) begin
          r_err <= 1'b1;
        end else begin
          r_size <= cfg_lcu_size; r_x <= '0; r_y <= '0;
          r_prm_addr <= '0; r_err <= 1'b0;
        end
      end
      if (r_state == S_PARAM1) begin
        r_pix_addr <= w_base; r_row <= '0; r_col <= '0;
        r_iss_done <= 1'b0; r_out_cnt <= '0; r_skid_v <= 1'b0;
      end
      if (r_state == S_PARAM2) begin
        r_prm <= prm_data; r_lcu_x <= r_x; r_lcu_y <= r_y;
      end
      if (w_issue) begin
        if (w_col_last && w_row_last) begin
          r_iss_done <= 1'b1;
        end else begin
          r_col <= w_nxt_col; r_row <= w_nxt_row; r_pix_addr <= w_nxt_addr;
        end
      end
      // Read returning while IPF is busy parks in the skid until busy drops
      if ((r_state == S_STREAM) && busy && r_dvld) begin
        r_skid <= pix_data; r_skid_v <= 1'b1;
      end
      if (w_out) begin
        r_din     <= r_skid_v ? r_skid : pix_data;
        r_skid_v  <= 1'b0;
        r_out_cnt <= r_out_cnt + 13'd1;
      end
      if (w_fin) begin
        r_x <= w_nx; r_y <= w_ny;
        if (!w_last_lcu) r_prm_addr <= w_nxt_idx;
        if (w_to && !finish) r_err <= 1'b1;
      end
    end
  end

  assign prm_addr     = r_prm_addr;
  assign pix_addr     = r_pix_addr;
  assign in_en        = r_in_en;
  assign din          = r_din;
  assign ipf_type     = r_prm[23:22];
  assign ipf_band_pos = r_prm[21:17];
  assign ipf_wo_class = r_prm[16];
  assign ipf_offset   = r_prm[15:0];
  assign lcu_x        = r_lcu_x;
  assign lcu_y        = r_lcu_y;
  assign lcu_size     = r_size;
  assign done         = r_done;
  assign err          = r_err;

endmodule

// File: tb/tb_ipf_lcu_sched.sv
// Scoreboard bench for ipf_lcu_sched: frame/param RAM models, IPF finish responder.
`timescale 1ns/1ps
module tb_ipf_lcu_sched;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, busy = 1'b0, finish = 1'b0;
  logic [1:0]  cfg_lcu_size = 2'd0;
  logic [23:0] prm_data;
  logic [7:0]  pix_data;
  logic [5:0]  prm_addr;
  logic [13:0] pix_addr;
  logic        in_en, ipf_wo_class, done, err;
  logic [7:0]  din;
  logic [1:0]  ipf_type, lcu_size;
  logic [4:0]  ipf_band_pos;
  logic [15:0] ipf_offset;
  logic [2:0]  lcu_x, lcu_y;

  ipf_lcu_sched #(.FRAME_W(128), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_lcu_size(cfg_lcu_size),
    .prm_addr(prm_addr), .prm_data(prm_data), .pix_addr(pix_addr), .pix_data(pix_data),
    .in_en(in_en), .din(din), .ipf_type(ipf_type), .ipf_band_pos(ipf_band_pos),
    .ipf_wo_class(ipf_wo_class), .ipf_offset(ipf_offset), .lcu_x(lcu_x), .lcu_y(lcu_y),
    .lcu_size(lcu_size), .busy(busy), .finish(finish), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  pix;
    logic [23:0] prm;
    logic [7:0]  pos;   // {x, y, size}
    logic        first;
    logic [13:0] base;
    logic [5:0]  pidx;
  } exp_t;

  exp_t sb[$];
  int   total = 0, bad = 0;
  int   done_cnt = 0, lcu_pix = 0, lcus_streamed = 0, fin_timer = 0, cur_nn = 256;
  bit   fin_en = 1'b1;
  logic [13:0] pa_d1 = '0, pa_d2 = '0;

  function automatic logic [7:0] pix_f(input logic [13:0] a);
    return 8'(a ^ (a >> 5) ^ (a >> 10));
  endfunction

  function automatic logic [23:0] prm_f(input logic [5:0] i);
    return 24'(32'(i) * 32'h2F1B7 + 32'h13579B);
  endfunction

  always @(posedge clk) begin
    pix_data <= pix_f(pix_addr);
    prm_data <= prm_f(prm_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_prm_addr"}, 32'(prm_addr), 0);
    chk({tag, "_pix_addr"}, 32'(pix_addr), 0);
    chk({tag, "_in_en"}, 32'(in_en), 0);
    chk({tag, "_din"}, 32'(din), 0);
    chk({tag, "_params"}, 32'({ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset}), 0);
    chk({tag, "_pos"}, 32'({lcu_x, lcu_y, lcu_size}), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  task automatic push_frame(input logic [1:0] sz);
    int n = 16 << sz;
    int l = 8 >> sz;
    exp_t e;
    cur_nn = n * n;
    for (int y = 0; y < l; y++)
      for (int x = 0; x < l; x++)
        for (int r = 0; r < n; r++)
          for (int c = 0; c < n; c++) begin
            e.pix   = pix_f(14'((y * n + r) * 128 + x * n + c));
            e.prm   = prm_f(6'(y * l + x));
            e.pos   = {3'(x), 3'(y), sz};
            e.first = (r == 0) && (c == 0);
            e.base  = 14'(y * n * 128 + x * n);
            e.pidx  = 6'(y * l + x);
            sb.push_back(e);
          end
  endtask

  task automatic pulse_start(input logic [1:0] sz);
    cfg_lcu_size = sz;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done_cnt >= target), 1);
    repeat (5) @(negedge clk);
    chk("done_once", 32'(done_cnt), 32'(target));
    chk("sb_drained", 32'(sb.size()), 0);
  endtask

  // Output monitor and IPF finish responder, sampled 1ns after the edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!reset) begin
      lcu_pix = 0; fin_timer = 0; finish = 1'b0;
    end else begin
      if (finish) finish = 1'b0;
      if (fin_timer > 0) begin
        fin_timer--;
        if (fin_timer == 0) finish = 1'b1;
      end
      if (done) done_cnt++;
      if (in_en) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'(sb.size()), 1);
        end else begin
          e = sb.pop_front();
          chk("din", 32'(din), 32'(e.pix));
          chk("params", 32'({ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset}), 32'(e.prm));
          chk("lcu_pos", 32'({lcu_x, lcu_y, lcu_size}), 32'(e.pos));
          if (e.first) begin
            chk("lcu_base_addr", 32'(pa_d2), 32'(e.base));
            chk("prm_addr", 32'(prm_addr), 32'(e.pidx));
          end
        end
        lcu_pix++;
        if (lcu_pix == cur_nn) begin
          lcu_pix = 0;
          lcus_streamed++;
          if (fin_en) fin_timer = 5;
        end
      end
    end
    pa_d2 = pa_d1;
    pa_d1 = pix_addr;
  end

  initial begin
    int n;
    bit act;
    // reset state
    repeat (3) @(negedge clk);
    chk_zero("rst");
    reset = 1'b1;
    @(negedge clk);

    // reserved size: err set, nothing moves
    pulse_start(2'd3);
    act = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (pix_addr != 0 || in_en || prm_addr != 0) act = 1'b1;
    end
    chk("rsv_noact", 32'(act), 0);
    chk("rsv_err", 32'(err), 1);

    // 16x16 frame, with start->in_en latency
    push_frame(2'd0);
    pulse_start(2'd0);
    for (int k = 1; k <= 4; k++) begin
      chk("lat_in_en", 32'(in_en), 32'(k == 4));
      if (k == 1) chk("err_cleared", 32'(err), 0);
      if (k < 4) @(negedge clk);
    end
    wait_done(1, 20000);

    // 64x64 frame
    push_frame(2'd2);
    pulse_start(2'd2);
    wait_done(2, 20000);

    // 32x32 frame with a 3-cycle busy stall mid-row
    push_frame(2'd1);
    pulse_start(2'd1);
    n = 0;
    while (lcu_pix < 20 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("stall_reached", 32'(lcu_pix >= 20), 1);
    chk("stall_pre_in_en", 32'(in_en), 1);
    busy = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("stall_gap", 32'(in_en), 32'(k > 3));
      if (k == 3) busy = 1'b0;
    end
    wait_done(3, 20000);

    // reset during LCU 5 stream, then restart from LCU(0,0)
    push_frame(2'd0);
    pulse_start(2'd0);
    n = 0;
    while (!(in_en && lcu_x == 3'd5) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_lcu5_reached", 32'(lcu_x), 5);
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    chk_zero("mid_rst");
    reset = 1'b1;
    @(negedge clk);
    push_frame(2'd2);
    pulse_start(2'd2);
    wait_done(4, 20000);

`ifdef IPF_SCHED_TIMEOUT_EN
    // watchdog: no finish for LCU 0
    fin_en = 1'b0;
    push_frame(2'd0);
    pulse_start(2'd0);
    n = lcus_streamed;
    while (lcus_streamed == n && n < 1000000) begin
      @(negedge clk);
      if (lcus_streamed == n && total > 0 && sb.size() == 0) break;
    end
    chk("to_streamed", 32'(lcus_streamed), 32'(n + 1));
    repeat (15) @(negedge clk);
    chk("to_prm_pre", 32'(prm_addr), 0);
    chk("to_err_pre", 32'(err), 0);
    @(negedge clk);
    chk("to_prm_post", 32'(prm_addr), 1);
    chk("to_err_post", 32'(err), 1);
    fin_en = 1'b1;
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench timeout");
  end

endmodule
